// File: rtl/regbank_sequencer_pkg.sv
// Shared definitions for the register-bank sequencer: opcodes, bank register
// indices, sequencer state encoding and small opcode classification helpers.
package regbank_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MOV   = 3'd1,
    OP_LDI   = 3'd2,
    OP_INC   = 3'd3,
    OP_FETCH = 3'd4,
    OP_PUSH  = 3'd5,
    OP_POP   = 3'd6,
    OP_STA   = 3'd7
  } opcode_e;

  // Fixed register-bank layout
  localparam logic [2:0] REG_PC         = 3'd0;
  localparam logic [2:0] REG_SP         = 3'd1;
  localparam logic [2:0] REG_DPTR       = 3'd2;
  localparam logic [2:0] REG_AREG       = 3'd3;
  localparam logic [2:0] REG_TVP        = 3'd4;
  localparam logic [2:0] REG_TEMP       = 3'd5;
  localparam logic [2:0] REG_CTE_NEGONE = 3'd6;
  localparam logic [2:0] REG_ACC        = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_ADDR = 3'd2,
    ST_MEM  = 3'd3,
    ST_POST = 3'd4
  } state_e;

  // Ops whose result lands in op_dst (and so can hit the constant register)
  function automatic logic writes_dst(input opcode_e op);
    return (op == OP_MOV) || (op == OP_LDI) || (op == OP_INC) ||
           (op == OP_FETCH) || (op == OP_POP);
  endfunction

  function automatic logic is_mem_write(input opcode_e op);
    return (op == OP_PUSH) || (op == OP_STA);
  endfunction

  // Pointer register that supplies the memory address for a memory op
  function automatic logic [2:0] ptr_reg(input opcode_e op);
    case (op)
      OP_FETCH: return REG_PC;
      OP_STA:   return REG_DPTR;
      default:  return REG_SP;
    endcase
  endfunction

endpackage

// File: rtl/regbank_sequencer_mem_if.sv
// Memory req/ack port: registered address/write data, request held while the
// sequencer waits in its memory state.
module regbank_seq_mem_if #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  active,
  input  logic                  is_write,
  input  logic [DATA_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic                  mem_ack,
  output logic                  ack_hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  // Capture address and write data once, keep them stable through the request
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (load) begin
      mem_addr_d  = addr_in;
      mem_wdata_d = wdata_in;
    end
  end

  // Address/data registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req   = active;
  assign mem_we    = active && is_write;
  assign ack_hit   = active && mem_ack;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: rtl/regbank_sequencer.sv
// Register-bank sequencer: accepts one micro-op at a time and drives the bank
// write/read port, sequencing memory ops over the req/ack memory port.
module regbank_sequencer
  import regbank_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [2:0]            op_code,
  input  logic [ADDR_WIDTH-1:0] op_dst,
  input  logic [ADDR_WIDTH-1:0] op_src,
  input  logic [DATA_WIDTH-1:0] op_imm,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  rb_w_en,
  output logic [ADDR_WIDTH-1:0] rb_w_addr,
  output logic [ADDR_WIDTH-1:0] rb_r_addr,
  output logic [DATA_WIDTH-1:0] rb_w_data,
  input  logic [DATA_WIDTH-1:0] rb_busA,
  input  logic [DATA_WIDTH-1:0] rb_busB,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam logic [DATA_WIDTH-1:0] ONE   = DATA_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_PC  = ADDR_WIDTH'(REG_PC);
  localparam logic [ADDR_WIDTH-1:0] A_SP  = ADDR_WIDTH'(REG_SP);
  localparam logic [ADDR_WIDTH-1:0] A_CTE = ADDR_WIDTH'(REG_CTE_NEGONE);

  state_e                state_q, state_d;
  opcode_e               op_q, op_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  mem_load;
  logic [DATA_WIDTH-1:0] mem_addr_nxt;
  logic                  mem_active;
  logic                  mem_ack_hit;
  logic                  op_err;
  logic [DATA_WIDTH-1:0] bus_b_inc;
  logic [DATA_WIDTH-1:0] bus_b_dec;

  assign bus_b_inc  = rb_busB + ONE;
  assign bus_b_dec  = rb_busB - ONE;
  assign op_err     = writes_dst(op_q) && (dst_q == A_CTE);
  assign mem_active = (state_q == ST_MEM);
  assign op_ready   = (state_q == ST_IDLE);

  // Next-state, bank port and retirement logic
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dst_d        = dst_q;
    src_d        = src_q;
    imm_d        = imm_q;
    data_d       = data_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    result_d     = result_q;
    wr_req       = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    rb_r_addr    = '0;
    mem_load     = 1'b0;
    mem_addr_nxt = '0;

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          op_d    = opcode_e'(op_code);
          dst_d   = op_dst;
          src_d   = op_src;
          imm_d   = op_imm;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (op_q)
          OP_NOP: begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            result_d = '0;
          end
          OP_MOV: begin
            rb_r_addr = src_q;
            wr_req    = 1'b1;
            wr_addr   = dst_q;
            wr_data   = rb_busB;
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            err_d     = op_err;
            result_d  = rb_busB;
          end
          OP_LDI: begin
            wr_req   = 1'b1;
            wr_addr  = dst_q;
            wr_data  = imm_q;
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            err_d    = op_err;
            result_d = imm_q;
          end
          OP_INC: begin
            rb_r_addr = dst_q;
            wr_req    = 1'b1;
            wr_addr   = dst_q;
            wr_data   = bus_b_inc;
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            err_d     = op_err;
            result_d  = bus_b_inc;
          end
          OP_PUSH: begin
            rb_r_addr = src_q;
            data_d    = rb_busB;
            state_d   = ST_ADDR;
          end
          OP_STA: begin
            data_d  = rb_busA;
            state_d = ST_ADDR;
          end
          default: begin
            state_d = ST_ADDR;
          end
        endcase
      end

      ST_ADDR: begin
        rb_r_addr    = ADDR_WIDTH'(ptr_reg(op_q));
        mem_load     = 1'b1;
        mem_addr_nxt = rb_busB;
        // POP pre-increments SP and uses the incremented value as the address
        if (op_q == OP_POP) begin
          mem_addr_nxt = bus_b_inc;
          wr_req       = 1'b1;
          wr_addr      = A_SP;
          wr_data      = bus_b_inc;
        end
        state_d = ST_MEM;
      end

      ST_MEM: begin
        if (mem_ack_hit) begin
          if ((op_q == OP_FETCH) || (op_q == OP_POP)) begin
            wr_req  = 1'b1;
            wr_addr = dst_q;
            wr_data = mem_rdata;
            data_d  = mem_rdata;
          end
          if ((op_q == OP_FETCH) || (op_q == OP_PUSH)) begin
            state_d = ST_POST;
          end else begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            err_d    = op_err;
            result_d = (op_q == OP_POP) ? mem_rdata : data_q;
          end
        end
      end

      ST_POST: begin
        if (op_q == OP_FETCH) begin
          rb_r_addr = A_PC;
          wr_req    = 1'b1;
          wr_addr   = A_PC;
          wr_data   = bus_b_inc;
        end else begin
          rb_r_addr = A_SP;
          wr_req    = 1'b1;
          wr_addr   = A_SP;
          wr_data   = bus_b_dec;
        end
        state_d  = ST_IDLE;
        done_d   = 1'b1;
        err_d    = op_err;
        result_d = data_q;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rb_w_en   = wr_req && (wr_addr != A_CTE);
  assign rb_w_addr = wr_addr;
  assign rb_w_data = wr_data;

  // State, latched op and retirement registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      dst_q    <= '0;
      src_q    <= '0;
      imm_q    <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      imm_q    <= imm_d;
      data_q   <= data_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

  regbank_seq_mem_if #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem_if (
    .clk       (clk),
    .rst       (rst),
    .load      (mem_load),
    .active    (mem_active),
    .is_write  (is_mem_write(op_q)),
    .addr_in   (mem_addr_nxt),
    .wdata_in  (data_q),
    .mem_ack   (mem_ack),
    .ack_hit   (mem_ack_hit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

endmodule
